// File: rtl/rotary_quad_multi.sv
// rotary_quad_multi: multi-channel quadrature rotary-encoder front end.
// Per pin: 2-FF sync + debounce; per channel: detent decode and signed position counter.
module rotary_quad_multi #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned STEPS    = 4,
    parameter int unsigned SATURATE = 0
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [2*NUM_CH-1:0]     rotary_in,
    input  logic [NUM_CH-1:0]       clear,
    output logic [NUM_CH-1:0]       rotary_cw,
    output logic [NUM_CH-1:0]       rotary_ccw,
    output logic [NUM_CH*CNT_W-1:0] position
);

    localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic signed [3:0] ACC_TOP = 4'(STEPS);
    localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic [2*NUM_CH-1:0] sync1, sync2, deb, deb_prev;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            deb_prev <= '0;
        end else begin
            sync1    <= rotary_in;
            sync2    <= sync1;
            deb_prev <= deb;
        end
    end

    for (genvar p = 0; p < 2*NUM_CH; p++) begin : g_pin
        logic [DB_W-1:0] cnt;
        logic            deb_bit;

        // A new level is taken on the edge where the stable count would reach DEBOUNCE.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                cnt     <= '0;
                deb_bit <= 1'b0;
            end else if (sync2[p] == deb_bit) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt     <= '0;
                deb_bit <= sync2[p];
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end

        assign deb[p] = deb_bit;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]              prev_idx, cur_idx, diff;
        logic signed [3:0]       acc, acc_sum, acc_next;
        logic                    fire_cw, fire_ccw;
        logic signed [CNT_W-1:0] pos, pos_next;
        logic                    cw_q, ccw_q;

        always_comb begin
            // {B,A} -> index in the CW Gray cycle 00,01,11,10; diff 1 = CW, 3 = CCW, 2 = invalid.
            prev_idx = {deb_prev[2*c+1], deb_prev[2*c+1] ^ deb_prev[2*c]};
            cur_idx  = {deb[2*c+1], deb[2*c+1] ^ deb[2*c]};
            diff     = cur_idx - prev_idx;
            acc_sum  = acc;
            if (diff == 2'd1) begin
                acc_sum = acc + 4'sd1;
            end else if (diff == 2'd3) begin
                acc_sum = acc - 4'sd1;
            end
            fire_cw  = (acc_sum == ACC_TOP);
            fire_ccw = (acc_sum == -ACC_TOP);
            if (diff == 2'd2 || fire_cw || fire_ccw) begin
                acc_next = '0;
            end else begin
                acc_next = acc_sum;
            end

            pos_next = pos;
            if (clear[c]) begin
                pos_next = '0;
            end else if (fire_cw) begin
                if (SATURATE == 0 || pos != POS_MAX) pos_next = pos + CNT_W'(1);
            end else if (fire_ccw) begin
                if (SATURATE == 0 || pos != POS_MIN) pos_next = pos - CNT_W'(1);
            end
        end

        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                acc   <= '0;
                pos   <= '0;
                cw_q  <= 1'b0;
                ccw_q <= 1'b0;
            end else begin
                acc   <= acc_next;
                pos   <= pos_next;
                cw_q  <= fire_cw;
                ccw_q <= fire_ccw;
            end
        end

        assign rotary_cw[c]                 = cw_q;
        assign rotary_ccw[c]                = ccw_q;
        assign position[c*CNT_W +: CNT_W]   = pos;
    end

endmodule

// File: tb/tb_rotary_quad_multi.sv
// tb_rotary_quad_multi: scoreboard bench for rotary_quad_multi.
// Detent events are predicted when pins are driven and matched against DUT pulses.
module tb_rotary_quad_multi;

    localparam int DB   = 4;
    localparam int HOLD = 10;

    typedef struct {
        int         cyc;
        logic [1:0] cw;
        logic [1:0] ccw;
        logic [15:0] pos;
    } ev_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rin   = '0;
    logic [1:0]  clr   = '0;
    logic [1:0]  cw, ccw;
    logic [15:0] pos;
    logic [3:0]  rin4  = '0;
    logic [1:0]  clr4  = '0;
    logic [1:0]  cw_s, ccw_s, cw_w, ccw_w;
    logic [7:0]  pos_s, pos_w;

    ev_t        sb[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_cw_s = 0;
    int         n_cw_w = 0;
    logic [1:0] m_pin [2];
    int         m_acc [2];
    logic [7:0] m_pos [2];

    always #5 clk = ~clk;

    rotary_quad_multi #(.NUM_CH(2), .CNT_W(8), .DEBOUNCE(DB), .STEPS(4), .SATURATE(0)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .rotary_in(rin), .clear(clr),
        .rotary_cw(cw), .rotary_ccw(ccw), .position(pos)
    );

    rotary_quad_multi #(.NUM_CH(2), .CNT_W(4), .DEBOUNCE(DB), .STEPS(4), .SATURATE(1)) dut_s (
        .clk_clk(clk), .reset_reset_n(rst_n), .rotary_in(rin4), .clear(clr4),
        .rotary_cw(cw_s), .rotary_ccw(ccw_s), .position(pos_s)
    );

    rotary_quad_multi #(.NUM_CH(2), .CNT_W(4), .DEBOUNCE(DB), .STEPS(4), .SATURATE(0)) dut_w (
        .clk_clk(clk), .reset_reset_n(rst_n), .rotary_in(rin4), .clear(clr4),
        .rotary_cw(cw_w), .rotary_ccw(ccw_w), .position(pos_w)
    );

    function automatic int gray_idx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // One cycle; any pulse on the main DUT is matched against the scoreboard head.
    task automatic step();
        ev_t e;
        @(negedge clk);
        cyc++;
        if (cw_s[0]) n_cw_s++;
        if (cw_w[0]) n_cw_w++;
        if ((cw | ccw) !== 2'b00) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: cyc=%0d got cw=%b ccw=%b, want no pulse",
                         cyc, cw, ccw);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || cw !== e.cw || ccw !== e.ccw || pos !== e.pos) begin
                    n_fail++;
                    $display("FAIL pulse_event: got cyc=%0d cw=%b ccw=%b pos=%h, want cyc=%0d cw=%b ccw=%b pos=%h",
                             cyc, cw, ccw, pos, e.cyc, e.cw, e.ccw, e.pos);
                end
            end
        end
    endtask

    // Drive both channels' pins, predict any detent event, then hold HOLD cycles.
    task automatic drive(input logic [1:0] p0, input logic [1:0] p1);
        logic [1:0] nv [2];
        ev_t        e;
        bit         fire;
        int         oi, ni;
        nv[0] = p0;
        nv[1] = p1;
        fire  = 1'b0;
        e.cyc = cyc + 3 + DB;
        e.cw  = 2'b00;
        e.ccw = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            oi = gray_idx(m_pin[ch]);
            ni = gray_idx(nv[ch]);
            if (ni == (oi + 1) % 4) m_acc[ch]++;
            else if (oi == (ni + 1) % 4) m_acc[ch]--;
            else if (ni != oi) m_acc[ch] = 0;
            if (m_acc[ch] == 4) begin
                e.cw[ch] = 1'b1;
                m_acc[ch] = 0;
                m_pos[ch] = m_pos[ch] + 8'd1;
                fire = 1'b1;
            end else if (m_acc[ch] == -4) begin
                e.ccw[ch] = 1'b1;
                m_acc[ch] = 0;
                m_pos[ch] = m_pos[ch] - 8'd1;
                fire = 1'b1;
            end
            if (clr[ch]) m_pos[ch] = 8'd0;
            m_pin[ch] = nv[ch];
        end
        e.pos = {m_pos[1], m_pos[0]};
        if (fire) sb.push_back(e);
        rin = {p1, p0};
        repeat (HOLD) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({cw, ccw, pos} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_main: got cw=%b ccw=%b pos=%h, want all zero", cw, ccw, pos);
        end
        n_cmp++;
        if ({cw_s, ccw_s, pos_s, cw_w, ccw_w, pos_w} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_small: got pos_s=%h pos_w=%h, want zero", pos_s, pos_w);
        end
        rst_n = 1'b1;
        repeat (HOLD) step();
        n_cmp++;
        if (pos !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_release_pos: got %h, want 0000", pos);
        end
    endtask

    task automatic test_cw_detent();
        drive(2'b01, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b10, 2'b00);
        drive(2'b00, 2'b00);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL cw_missed: got %0d pending, want 0", sb.size());
        end
        n_cmp++;
        if (pos !== 16'h0001) begin
            n_fail++;
            $display("FAIL cw_position: got %h, want 0001", pos);
        end
    endtask

    task automatic test_ccw_reversal();
        clr = 2'b01;
        step();
        clr = 2'b00;
        m_pos[0] = 8'd0;
        step();
        n_cmp++;
        if (pos[7:0] !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_ch0: got %h, want 00", pos[7:0]);
        end
        drive(2'b10, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b01, 2'b00);
        drive(2'b00, 2'b00);
        drive(2'b01, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b10, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b01, 2'b00);
        drive(2'b00, 2'b00);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL ccw_missed: got %0d pending, want 0", sb.size());
        end
        n_cmp++;
        if (pos !== 16'h00FF) begin
            n_fail++;
            $display("FAIL ccw_position: got %h, want 00ff", pos);
        end
    endtask

    task automatic test_glitch_jump();
        rin[0] = 1'b1;
        repeat (3) step();
        rin[0] = 1'b0;
        repeat (HOLD + 2) step();
        n_cmp++;
        if (pos !== 16'h00FF) begin
            n_fail++;
            $display("FAIL glitch_position: got %h, want 00ff", pos);
        end
        drive(2'b01, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b00, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b10, 2'b00);
        drive(2'b00, 2'b00);
        drive(2'b01, 2'b00);
        n_cmp++;
        if (pos !== 16'h00FF) begin
            n_fail++;
            $display("FAIL jump_no_event: got %h, want 00ff", pos);
        end
        drive(2'b11, 2'b00);
        n_cmp++;
        if (sb.size() != 0 || pos !== 16'h0000) begin
            n_fail++;
            $display("FAIL jump_recover: got pos=%h pending=%0d, want pos=0000 pending=0",
                     pos, sb.size());
        end
    endtask

    task automatic test_simultaneous();
        clr = 2'b10;
        m_pos[1] = 8'd0;
        step();
        drive(2'b10, 2'b01);
        drive(2'b00, 2'b11);
        drive(2'b01, 2'b10);
        drive(2'b11, 2'b00);
        clr = 2'b00;
        step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL simul_missed: got %0d pending, want 0", sb.size());
        end
        n_cmp++;
        if (pos !== 16'h0001) begin
            n_fail++;
            $display("FAIL simul_position: got %h, want 0001", pos);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] seq [4];
        seq[0] = 2'b01;
        seq[1] = 2'b11;
        seq[2] = 2'b10;
        seq[3] = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            for (int s = 0; s < 4; s++) begin
                rin4[1:0] = seq[s];
                repeat (HOLD) step();
            end
            if (k == 8) begin
                n_cmp++;
                if (pos_w[3:0] !== 4'h8 || pos_s[3:0] !== 4'h7) begin
                    n_fail++;
                    $display("FAIL sat_after8: got wrap=%h sat=%h, want wrap=8 sat=7",
                             pos_w[3:0], pos_s[3:0]);
                end
            end
        end
        n_cmp++;
        if (n_cw_s !== 9 || n_cw_w !== 9) begin
            n_fail++;
            $display("FAIL sat_pulses: got sat=%0d wrap=%0d, want 9 each", n_cw_s, n_cw_w);
        end
        n_cmp++;
        if (pos_w !== 8'h09 || pos_s !== 8'h07) begin
            n_fail++;
            $display("FAIL sat_after9: got wrap=%h sat=%h, want wrap=09 sat=07", pos_w, pos_s);
        end
    endtask

    task automatic test_reset_mid();
        drive(2'b11, 2'b01);
        drive(2'b11, 2'b11);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cw, ccw, pos} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_async: got cw=%b ccw=%b pos=%h, want all zero", cw, ccw, pos);
        end
        repeat (3) step();
        rst_n = 1'b1;
        for (int ch = 0; ch < 2; ch++) begin
            m_acc[ch] = 0;
            m_pos[ch] = 8'd0;
            m_pin[ch] = 2'b11;
        end
        repeat (HOLD + 5) step();
        n_cmp++;
        if (pos !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_release_11: got %h, want 0000", pos);
        end
        drive(2'b11, 2'b10);
        drive(2'b11, 2'b00);
        drive(2'b11, 2'b01);
        drive(2'b11, 2'b11);
        n_cmp++;
        if (sb.size() != 0 || pos !== 16'h0100) begin
            n_fail++;
            $display("FAIL reset_next_detent: got pos=%h pending=%0d, want pos=0100 pending=0",
                     pos, sb.size());
        end
    endtask

    initial begin
        for (int ch = 0; ch < 2; ch++) begin
            m_pin[ch] = 2'b00;
            m_acc[ch] = 0;
            m_pos[ch] = 8'd0;
        end
        test_reset();
        test_cw_detent();
        test_ccw_reversal();
        test_glitch_jump();
        test_simultaneous();
        test_saturate();
        test_reset_mid();
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
